// File: rtl/serial_word_packer_if.sv
// Serial-bit input and parallel-word output handshakes for serial_word_packer.
// master is the environment side; slave is the packer itself.
interface serial_word_packer_if #(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_parity;
  logic             word_valid;
  logic             word_ready;

  modport master (
    output bit_in, bit_valid, word_ready,
    input  bit_ready, word_out, word_parity, word_valid
  );

  modport slave (
    input  bit_in, bit_valid, word_ready,
    output bit_ready, word_out, word_parity, word_valid
  );
endinterface

// File: rtl/serial_word_packer.sv
// Packs an LSB-first serial bit stream into WIDTH-bit words with even parity.
// A one-word stall register absorbs a completed word while the output is blocked.
module serial_word_packer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clock,
  input  logic                  clear,
  serial_word_packer_if.slave   bus
);

  typedef enum logic {FILL, STALL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh, sh_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] st, st_next;
  logic [WIDTH-1:0] word_q, word_next;
  logic             parity_q, parity_next;
  logic             valid_q, valid_next;

  logic             accept;
  logic             complete;
  logic             out_free;
  logic [WIDTH-1:0] w;

  assign accept   = (state == FILL) && bus.bit_valid;
  assign complete = accept && (cnt == CNT_W'(WIDTH - 1));
  assign out_free = !valid_q || bus.word_ready;
  assign w        = {bus.bit_in, sh[WIDTH-2:0]};

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= FILL;
      sh       <= '0;
      cnt      <= '0;
      st       <= '0;
      word_q   <= '0;
      parity_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_next;
      sh       <= sh_next;
      cnt      <= cnt_next;
      st       <= st_next;
      word_q   <= word_next;
      parity_q <= parity_next;
      valid_q  <= valid_next;
    end
  end

  // A completing word goes straight to the output if it is free this cycle,
  // otherwise it parks in st and input is frozen until the output drains.
  always_comb begin
    state_next  = state;
    sh_next     = sh;
    cnt_next    = cnt;
    st_next     = st;
    word_next   = word_q;
    parity_next = parity_q;
    valid_next  = valid_q;

    case (state)
      FILL: begin
        if (accept) begin
          sh_next[cnt] = bus.bit_in;
          cnt_next     = complete ? '0 : cnt + CNT_W'(1);
        end
        if (complete) begin
          if (out_free) begin
            word_next   = w;
            parity_next = ^w;
            valid_next  = 1'b1;
          end else begin
            st_next    = w;
            state_next = STALL;
          end
        end else if (valid_q && bus.word_ready) begin
          valid_next = 1'b0;
        end
      end
      STALL: begin
        if (bus.word_ready) begin
          word_next   = st;
          parity_next = ^st;
          valid_next  = 1'b1;
          state_next  = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  assign bus.bit_ready   = (state == FILL);
  assign bus.word_out    = word_q;
  assign bus.word_parity = parity_q;
  assign bus.word_valid  = valid_q;

endmodule
